// File: rtl/mmio_uart_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_uart_ctrl
//
// Memory-mapped I/O block on the CPU data-memory path. Claims addresses whose
// top nibble is 4'b1000 and bridges CPU loads/stores to the on-chip UART
// through a TX FIFO and an RX FIFO. Also provides a free-running cycle
// counter and a retired-instruction counter. Load data is registered, so it
// has the same one-cycle read latency as data memory.
//
// Register map (offset = addr[7:0]):
//   0x00 STATUS  (RO) bit0 TX not full, bit1 RX not empty, bit2 tx_overflow
//   0x04 RX_DATA (RO) RX head in [7:0]; a read pops (empty reads return 0)
//   0x08 TX_DATA (WO) store with we[0] pushes wdata[7:0]
//   0x10 CYCLE   (RO) cycle counter
//   0x14 INSTRET (RO) retired-instruction counter
//   0x18 CTR_RST (WO) any store clears CYCLE, INSTRET and tx_overflow
//
// Ports:
//   clk, rst            core clock, asynchronous active-low reset
//   addr, wdata, we, re CPU data-side access (execute-stage address)
//   inst_retired        one instruction retired this cycle
//   rdata               load data, valid the cycle after re
//   uart_tx_*           byte stream towards the UART transmitter
//   uart_rx_*           byte stream from the UART receiver
// ---------------------------------------------------------------------------
module mmio_uart_ctrl #(
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  we,
   input  logic        re,
   input  logic        inst_retired,
   output logic [31:0] rdata,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam logic [TX_AW:0] TX_FULL_COUNT = (TX_AW+1)'(TX_DEPTH);
   localparam logic [RX_AW:0] RX_FULL_COUNT = (RX_AW+1)'(RX_DEPTH);

   localparam logic [7:0] OFF_STATUS  = 8'h00;
   localparam logic [7:0] OFF_RX_DATA = 8'h04;
   localparam logic [7:0] OFF_TX_DATA = 8'h08;
   localparam logic [7:0] OFF_CYCLE   = 8'h10;
   localparam logic [7:0] OFF_INSTRET = 8'h14;
   localparam logic [7:0] OFF_CTR_RST = 8'h18;

   logic              sel;
   logic [7:0]        off;
   logic              rd_req;
   logic [31:0]       read_value;

   logic [7:0]        tx_mem [TX_DEPTH];
   logic [TX_AW-1:0]  tx_wr_ptr;
   logic [TX_AW-1:0]  tx_rd_ptr;
   logic [TX_AW:0]    tx_count;
   logic              tx_full;
   logic              tx_pop;
   logic              tx_push_req;
   logic              tx_push;
   logic              tx_drop;
   logic              tx_overflow;

   logic [7:0]        rx_mem [RX_DEPTH];
   logic [RX_AW-1:0]  rx_wr_ptr;
   logic [RX_AW-1:0]  rx_rd_ptr;
   logic [RX_AW:0]    rx_count;
   logic              rx_empty;
   logic              rx_push;
   logic              rx_pop;

   logic              ctr_rst;
   logic [31:0]       cycle_count;
   logic [31:0]       instret_count;

   logic              unused_bits;

   // Address decode: only the top nibble selects this block, and only the low
   // byte picks the register, so the bits in between are deliberately ignored.
   assign sel         = (addr[31:28] == 4'b1000);
   assign off         = addr[7:0];
   assign rd_req      = re & sel;
   assign unused_bits = ^{addr[27:8], wdata[31:8]};

   // TX FIFO handshakes. A push into a full FIFO is still accepted when the
   // UART drains a byte in the same cycle; otherwise it is dropped and flagged.
   assign tx_full       = (tx_count == TX_FULL_COUNT);
   assign uart_tx_valid = (tx_count != '0);
   assign uart_tx_data  = tx_mem[tx_rd_ptr];
   assign tx_pop        = uart_tx_valid & uart_tx_ready;
   assign tx_push_req   = sel & (off == OFF_TX_DATA) & we[0];
   assign tx_push       = tx_push_req & (~tx_full | tx_pop);
   assign tx_drop       = tx_push_req & tx_full & ~tx_pop;

   // RX FIFO handshakes. The CPU pop only happens on a real load of RX_DATA
   // while there is something to pop; the UART push only while not full.
   assign rx_empty      = (rx_count == '0);
   assign uart_rx_ready = (rx_count != RX_FULL_COUNT);
   assign rx_push       = uart_rx_valid & uart_rx_ready;
   assign rx_pop        = rd_req & (off == OFF_RX_DATA) & ~rx_empty;

   assign ctr_rst = sel & (off == OFF_CTR_RST) & (we != 4'b0000);

   // Load mux. Everything here is taken from current state, so STATUS and the
   // RX head reflect the FIFOs before any push or pop happening this cycle.
   always_comb begin
      read_value = '0;
      case (off)
         OFF_STATUS:  read_value = {29'b0, tx_overflow, ~rx_empty, ~tx_full};
         OFF_RX_DATA: read_value = rx_empty ? 32'b0 : {24'b0, rx_mem[rx_rd_ptr]};
         OFF_CYCLE:   read_value = cycle_count;
         OFF_INSTRET: read_value = instret_count;
         default:     read_value = '0;
      endcase
   end

   // Registered load data: captured only on a selected load, held otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
      end else if (rd_req) begin
         rdata <= read_value;
      end
   end

   // FIFO storage needs no reset: the pointers and counts define what is valid.
   always_ff @(posedge clk) begin
      if (tx_push) begin
         tx_mem[tx_wr_ptr] <= wdata[7:0];
      end
      if (rx_push) begin
         rx_mem[rx_wr_ptr] <= uart_rx_data;
      end
   end

   // TX FIFO pointers, occupancy and the sticky overflow flag. Pointers are
   // exactly log2(depth) bits so they wrap on their own.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_wr_ptr   <= '0;
         tx_rd_ptr   <= '0;
         tx_count    <= '0;
         tx_overflow <= 1'b0;
      end else begin
         if (tx_push) begin
            tx_wr_ptr <= tx_wr_ptr + 1'b1;
         end
         if (tx_pop) begin
            tx_rd_ptr <= tx_rd_ptr + 1'b1;
         end
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: tx_count <= tx_count;
         endcase
         if (ctr_rst) begin
            tx_overflow <= 1'b0;
         end else if (tx_drop) begin
            tx_overflow <= 1'b1;
         end
      end
   end

   // RX FIFO pointers and occupancy; a simultaneous push and pop leaves the
   // count unchanged while both pointers advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) begin
            rx_wr_ptr <= rx_wr_ptr + 1'b1;
         end
         if (rx_pop) begin
            rx_rd_ptr <= rx_rd_ptr + 1'b1;
         end
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase
      end
   end

   // Performance counters. A CTR_RST store takes priority over the increment
   // so the counters read exactly zero on the following cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_count   <= '0;
         instret_count <= '0;
      end else if (ctr_rst) begin
         cycle_count   <= '0;
         instret_count <= '0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         if (inst_retired) begin
            instret_count <= instret_count + 32'd1;
         end
      end
   end

endmodule

// File: doc/mmio_uart_ctrl.md
Name: mmio_uart_ctrl

Overview:
Memory-mapped I/O block on the CPU data-memory path. It claims addresses whose top nibble is 4'b1000 and bridges CPU loads and stores to the on-chip UART through a TX FIFO and an RX FIFO. It also provides a cycle counter and a retired-instruction counter. Its read data feeds the writeback load-select path in parallel with dmem/BIOS data, with the same 1-cycle synchronous read latency as dmem.

Parameters:
TX_DEPTH, 8, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
addr  input  32  CPU data address (execute-stage ALU result)
wdata  input  32  store data, already lane-shifted
we  input  4  store byte enables
re  input  1  load request this cycle
inst_retired  input  1  one instruction retired this cycle
rdata  output  32  load data, valid the cycle after re
uart_tx_data  output  8  byte to UART transmitter
uart_tx_valid  output  1  TX FIFO non-empty
uart_tx_ready  input  1  UART accepts byte
uart_rx_data  input  8  byte from UART receiver
uart_rx_valid  input  1  UART has a byte
uart_rx_ready  output  1  RX FIFO not full

Behaviour:
- sel = (addr[31:28]==4'b1000). Offsets decoded on addr[7:0]. No access when sel=0.
- Register map:
  - 0x00 STATUS (RO): bit0 = TX not full; bit1 = RX not empty; bit2 = tx_overflow (sticky); others 0.
  - 0x04 RX_DATA (RO): [7:0] = RX head, upper bits 0. A read pops the FIFO. Reading when empty returns 0 and does not pop.
  - 0x08 TX_DATA (WO): a store with we[0]=1 pushes wdata[7:0]. A push while full is dropped and sets tx_overflow.
  - 0x10 CYCLE (RO): cycle count.
  - 0x14 INSTRET (RO): retired-instruction count.
  - 0x18 CTR_RST (WO): any store with we!=0 clears CYCLE, INSTRET and tx_overflow.
- Unmapped offsets: reads return 0; writes are ignored.
- Loads: rdata is registered and updated on the clock edge after re & sel. It holds its value otherwise. The RX pop and the rdata capture of the head occur on the same edge.
- Counters:
  - CYCLE +1 every cycle; INSTRET +1 when inst_retired=1.
  - Both wrap 0xFFFF_FFFF -> 0.
  - A CTR_RST write wins over the increment: the value is 0 on the next cycle.
- TX FIFO:
  - uart_tx_data = head, combinational from storage.
  - A pop occurs on uart_tx_valid & uart_tx_ready.
  - Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
  - Push and pop in the same cycle while empty is impossible, because valid=0.
- RX FIFO:
  - A push occurs on uart_rx_valid & uart_rx_ready.
  - A CPU pop and a UART push in the same cycle are both accepted.
  - uart_rx_ready = count<RX_DEPTH, registered-free (combinational from count).
- FIFO pointers are log2(DEPTH) bits wide and wrap naturally. The count is log2(DEPTH)+1 bits.
- Reset (rst=0, asynchronous) forces the following, regardless of any operation in flight:
  - rdata=0, counters=0, tx_overflow=0.
  - Both FIFOs empty: uart_tx_valid=0, uart_rx_ready=1.
- The STATUS value read reflects state before any same-cycle push or pop.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> rdata=0, uart_tx_valid=0, uart_rx_ready=1, load 0x8000_0000 returns 0x1.
- TX path:
  - Stimulus: with uart_tx_ready=0, store 0x41, 0x42 to 0x8000_0008, then raise ready.
  - Required: uart_tx_data is 0x41 then 0x42, and uart_tx_valid drops after 2 handshakes.
- TX overflow:
  - Stimulus: with ready=0, push 9 bytes into an 8-deep FIFO.
  - Required: STATUS reads 0x4 (bit0=0 while full, bit2=1). Only the first 8 bytes drain. A CTR_RST write clears bit2.
- RX path:
  - Stimulus: the UART delivers 0x55, then 0xAA.
  - Required: STATUS bit1=1. Loads of 0x8000_0004 return 0x55, then 0xAA, then 0 (FIFO empty, no pop). When RX is full with 8 bytes, uart_rx_ready=0.
- Simultaneous: CPU pop of RX and UART push in the same cycle at count=3 -> count stays 3, FIFO order is preserved.
- Counters:
  - Stimulus: pulse inst_retired 5 times in 20 cycles, then read.
  - Required: INSTRET=5. CYCLE is monotonic and matches the bench cycle count. After a CTR_RST store, CYCLE reads a small value (<=2) and INSTRET=0.
